mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_tag_fifo.sv | 72 +++++++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the memory-port arbiter.
//   ADDR_WIDTH / DATA_WIDTH : memory address and data widths
//   arb_state_e             : grant FSM states
//   idx_width()             : index width that never collapses to zero bits
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each outstanding read.
//   clk, rst_n : clock, synchronous active-low reset
//   push       : enqueue push_data (ignored while full, even if popping)
//   push_data  : requester index to enqueue
//   pop        : dequeue the head entry (ignored while empty)
//   head       : requester index at the head
//   full/empty : occupancy flags
//   count      : number of stored entries
module tag_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = idx_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // Full blocks a push regardless of a simultaneous pop.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters.
// Requests pass through combinationally; a stalled request is locked so the
// memory side sees stable values. Reads are tagged in order so responses
// route back to their issuer.
//   clk, rst_n            : clock, synchronous active-low reset
//   r_req_vld/rdy/we      : per-requester request handshake and direction
//   r_req_addr/wdata      : packed per-requester address / write data
//   m_req_vld/rdy/we      : memory request handshake and direction
//   m_req_addr/wdata      : memory address / write data
//   m_rsp_vld/rdy, data   : memory read response
//   r_rsp_vld/rdy         : per-requester response handshake
//   r_rsp_data            : read data broadcast to all requesters
//   busy                  : reads outstanding or a request presented
//   err_rsp               : sticky flag, response arrived with no read pending
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              r_req_vld,
    output logic [NUM_REQ-1:0]              r_req_rdy,
    input  logic [NUM_REQ-1:0]              r_req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   r_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   r_req_wdata,
    output logic                            m_req_vld,
    input  logic                            m_req_rdy,
    output logic                            m_req_we,
    output logic [ADDR_WIDTH-1:0]           m_req_addr,
    output logic [DATA_WIDTH-1:0]           m_req_wdata,
    input  logic                            m_rsp_vld,
    output logic                            m_rsp_rdy,
    input  logic [DATA_WIDTH-1:0]           m_rsp_data,
    output logic [NUM_REQ-1:0]              r_rsp_vld,
    input  logic [NUM_REQ-1:0]              r_rsp_rdy,
    output logic [DATA_WIDTH-1:0]           r_rsp_data,
    output logic                            busy,
    output logic                            err_rsp
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(OUTSTANDING) + 1;

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] locked_idx;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] grant_idx;
    logic             any_vld;
    logic             req_vld;
    logic             req_hs;
    int unsigned      cand;

    logic             tag_push;
    logic             tag_pop;
    logic             tag_full;
    logic             tag_empty;
    logic [IDX_W-1:0] tag_head;
    logic [CNT_W-1:0] tag_count;

    // Round-robin search starting at rr_ptr.
    always_comb begin
        winner  = rr_ptr;
        any_vld = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(rr_ptr) + k) % NUM_REQ;
            if (!any_vld && r_req_vld[IDX_W'(cand)]) begin
                any_vld = 1'b1;
                winner  = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A read is held back while the tag FIFO is full. Once locked, the
    // request already passed that check and no push can happen before its
    // own handshake, so the lock never needs to re-test it.
    always_comb begin
        state_nxt = state;
        grant_idx = winner;
        req_vld   = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                grant_idx = winner;
                req_vld   = any_vld && !(!r_req_we[winner] && tag_full);
                if (req_vld && !m_req_rdy) begin
                    state_nxt = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                grant_idx = locked_idx;
                req_vld   = r_req_vld[locked_idx];
                if (!req_vld || m_req_rdy) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
        if (!rst_n) begin
            req_vld = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            locked_idx <= '0;
            rr_ptr     <= '0;
        end else begin
            if (state == ARB_IDLE && state_nxt == ARB_LOCKED) begin
                locked_idx <= winner;
            end
            if (req_hs) begin
                rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
            end
        end
    end

    assign m_req_vld   = req_vld;
    assign m_req_we    = r_req_we[grant_idx];
    assign m_req_addr  = r_req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_req_wdata = r_req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign req_hs      = req_vld & m_req_rdy;
    assign tag_push    = req_hs & ~m_req_we;

    always_comb begin
        r_req_rdy = '0;
        if (req_vld) begin
            r_req_rdy[grant_idx] = m_req_rdy;
        end
    end

    // Response routing: with nothing pending the response is accepted and
    // dropped so the memory side never stalls on a stray beat.
    always_comb begin
        r_rsp_vld = '0;
        m_rsp_rdy = 1'b1;
        if (!tag_empty) begin
            r_rsp_vld[tag_head] = m_rsp_vld & rst_n;
            m_rsp_rdy           = r_rsp_rdy[tag_head];
        end
    end

    assign tag_pop    = m_rsp_vld & m_rsp_rdy & ~tag_empty;
    assign r_rsp_data = m_rsp_data;
    assign busy       = rst_n & ((tag_count != '0) | req_vld);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_rsp <= 1'b0;
        end else if (m_rsp_vld && tag_empty) begin
            err_rsp <= 1'b1;
        end
    end

    tag_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_push),
        .push_data (grant_idx),
        .pop       (tag_pop),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory
// requests and expected routed responses; a negedge monitor pops and compares
// on every handshake. Inline checks cover stalls, FIFO-full blocking, busy,
// err_rsp and reset behaviour.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned NR = 2;

    logic                       clk;
    logic                       rst_n;
    logic [NR-1:0]              r_req_vld;
    logic [NR-1:0]              r_req_rdy;
    logic [NR-1:0]              r_req_we;
    logic [NR*ADDR_WIDTH-1:0]   r_req_addr;
    logic [NR*DATA_WIDTH-1:0]   r_req_wdata;
    logic                       m_req_vld;
    logic                       m_req_rdy;
    logic                       m_req_we;
    logic [ADDR_WIDTH-1:0]      m_req_addr;
    logic [DATA_WIDTH-1:0]      m_req_wdata;
    logic                       m_rsp_vld;
    logic                       m_rsp_rdy;
    logic [DATA_WIDTH-1:0]      m_rsp_data;
    logic [NR-1:0]              r_rsp_vld;
    logic [NR-1:0]              r_rsp_rdy;
    logic [DATA_WIDTH-1:0]      r_rsp_data;
    logic                       busy;
    logic                       err_rsp;

    typedef struct {
        int                    idx;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    typedef struct {
        int                    idx;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    req_t er;
    rsp_t es;
    int   tests = 0;
    int   fails = 0;

    mem_port_arbiter #(
        .NUM_REQ     (NR),
        .OUTSTANDING (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .r_req_vld   (r_req_vld),
        .r_req_rdy   (r_req_rdy),
        .r_req_we    (r_req_we),
        .r_req_addr  (r_req_addr),
        .r_req_wdata (r_req_wdata),
        .m_req_vld   (m_req_vld),
        .m_req_rdy   (m_req_rdy),
        .m_req_we    (m_req_we),
        .m_req_addr  (m_req_addr),
        .m_req_wdata (m_req_wdata),
        .m_rsp_vld   (m_rsp_vld),
        .m_rsp_rdy   (m_rsp_rdy),
        .m_rsp_data  (m_rsp_data),
        .r_rsp_vld   (r_rsp_vld),
        .r_rsp_rdy   (r_rsp_rdy),
        .r_rsp_data  (r_rsp_data),
        .busy        (busy),
        .err_rsp     (err_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic vld, input logic we,
                           input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
        r_req_vld[i] = vld;
        r_req_we[i]  = we;
        r_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = a;
        r_req_wdata[i*DATA_WIDTH +: DATA_WIDTH] = d;
    endtask

    task automatic exp_r(input int i, input logic we,
                         input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
        req_t t;
        t.idx = i; t.we = we; t.addr = a; t.wdata = d;
        exp_req.push_back(t);
    endtask

    task automatic respond(input int i, input logic [DATA_WIDTH-1:0] d);
        rsp_t t;
        t.idx = i; t.data = d;
        exp_rsp.push_back(t);
        m_rsp_vld  = 1'b1;
        m_rsp_data = d;
        tick();
        m_rsp_vld  = 1'b0;
    endtask

    // Monitor: compare every request and response handshake to the scoreboard.
    always @(negedge clk) begin
        if (rst_n && m_req_vld && m_req_rdy) begin
            if (exp_req.size() == 0) begin
                tests++; fails++;
                $display("FAIL req_unexpected: got addr 0x%0h, expected no request", m_req_addr);
            end else begin
                er = exp_req.pop_front();
                chk("req_grant", r_req_rdy, 64'(1) << er.idx);
                chk("req_we", m_req_we, er.we);
                chk("req_addr", m_req_addr, er.addr);
                if (er.we) chk("req_wdata", m_req_wdata, er.wdata);
            end
        end
        if (|(r_rsp_vld & r_rsp_rdy)) begin
            if (exp_rsp.size() == 0) begin
                tests++; fails++;
                $display("FAIL rsp_unexpected: got r_rsp_vld 0x%0h, expected none", r_rsp_vld);
            end else begin
                es = exp_rsp.pop_front();
                chk("rsp_route", r_rsp_vld, 64'(1) << es.idx);
                chk("rsp_data", r_rsp_data, es.data);
                chk("rsp_m_rdy", m_rsp_rdy, 1);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        r_req_vld   = '1;
        r_req_we    = '0;
        r_req_addr  = '0;
        r_req_wdata = '0;
        m_req_rdy   = 1'b1;
        m_rsp_vld   = 1'b0;
        m_rsp_data  = '0;
        r_rsp_rdy   = '1;

        // Reset: outputs held low even with requesters valid.
        mid();
        chk("rst_m_req_vld", m_req_vld, 0);
        chk("rst_r_req_rdy", r_req_rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_r_rsp_vld", r_rsp_vld, 0);
        tick();
        rst_n = 1'b1;
        r_req_vld = '0;
        mid();
        chk("post_rst_err", err_rsp, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_vld", m_req_vld, 0);
        tick();

        // Both requesters read continuously: grants alternate 0,1,0,1.
        set_req(0, 1, 0, 16'h0100, '0);
        set_req(1, 1, 0, 16'h0201, '0);
        exp_r(0, 0, 16'h0100, '0);
        exp_r(1, 0, 16'h0201, '0);
        exp_r(0, 0, 16'h0100, '0);
        exp_r(1, 0, 16'h0201, '0);
        repeat (4) tick();
        r_req_vld = '0;
        mid();
        chk("s1_busy_full", busy, 1);
        chk("s1_idle_vld", m_req_vld, 0);
        tick();
        respond(0, 32'h1111_0000);
        respond(1, 32'h1111_0001);
        respond(0, 32'h1111_0002);
        respond(1, 32'h1111_0003);
        mid();
        chk("s1_drained_busy", busy, 0);
        tick();

        // r0 write moves rr_ptr to 1.
        set_req(0, 1, 1, 16'h0044, 32'h0000_0033);
        exp_r(0, 1, 16'h0044, 32'h0000_0033);
        tick();
        r_req_vld = '0;

        // Stalled r0 read stays locked although rr_ptr now favours r1.
        m_req_rdy = 1'b0;
        set_req(0, 1, 0, 16'h0010, '0);
        mid();
        chk("s2_vld_c1", m_req_vld, 1);
        chk("s2_addr_c1", m_req_addr, 16'h0010);
        chk("s2_rdy_c1", r_req_rdy, 0);
        tick();
        set_req(1, 1, 0, 16'h0020, '0);
        mid();
        chk("s2_addr_c2", m_req_addr, 16'h0010);
        chk("s2_we_c2", m_req_we, 0);
        tick();
        mid();
        chk("s2_addr_c3", m_req_addr, 16'h0010);
        chk("s2_vld_c3", m_req_vld, 1);
        tick();
        m_req_rdy = 1'b1;
        exp_r(0, 0, 16'h0010, '0);
        mid();
        chk("s2_rdy_hs", r_req_rdy, 2'b01);
        tick();
        r_req_vld[0] = 1'b0;
        exp_r(1, 0, 16'h0020, '0);
        mid();
        chk("s2_r1_grant", r_req_rdy, 2'b10);
        tick();
        r_req_vld = '0;
        respond(0, 32'h2222_0000);
        respond(1, 32'h2222_0001);

        // Four outstanding reads fill the FIFO; the fifth waits for a pop.
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1, 0, 16'h0040 + 16'(k), '0);
            exp_r(0, 0, 16'h0040 + 16'(k), '0);
            tick();
        end
        r_req_vld[0] = 1'b0;
        set_req(1, 1, 0, 16'h0051, '0);
        mid();
        chk("s3_blocked_vld", m_req_vld, 0);
        chk("s3_blocked_rdy", r_req_rdy, 0);
        chk("s3_busy", busy, 1);
        tick();
        mid();
        chk("s3_blocked_vld2", m_req_vld, 0);
        tick();
        begin
            rsp_t t;
            t.idx = 0; t.data = 32'h3333_0000;
            exp_rsp.push_back(t);
        end
        m_rsp_vld  = 1'b1;
        m_rsp_data = 32'h3333_0000;
        mid();
        chk("s3_pop_cycle_vld", m_req_vld, 0);
        tick();
        m_rsp_vld = 1'b0;
        exp_r(1, 0, 16'h0051, '0);
        mid();
        chk("s3_fifth_vld", m_req_vld, 1);
        tick();
        r_req_vld = '0;
        respond(0, 32'h3333_0001);
        respond(0, 32'h3333_0002);
        respond(0, 32'h3333_0003);
        respond(1, 32'h3333_0004);

        // r1 write: no tag pushed, busy drops right after the handshake.
        set_req(1, 1, 1, 16'h0077, 32'h0000_00A5);
        exp_r(1, 1, 16'h0077, 32'h0000_00A5);
        mid();
        chk("s4_we", m_req_we, 1);
        chk("s4_wdata", m_req_wdata, 32'h0000_00A5);
        chk("s4_busy", busy, 1);
        tick();
        r_req_vld = '0;
        mid();
        chk("s4_busy_after", busy, 0);
        tick();

        // Stray response with nothing outstanding.
        m_rsp_vld  = 1'b1;
        m_rsp_data = 32'h0000_DEAD;
        mid();
        chk("s5_m_rsp_rdy", m_rsp_rdy, 1);
        chk("s5_r_rsp_vld", r_rsp_vld, 0);
        chk("s5_err_before", err_rsp, 0);
        tick();
        m_rsp_vld = 1'b0;
        mid();
        chk("s5_err", err_rsp, 1);
        tick();
        tick();
        mid();
        chk("s5_err_sticky", err_rsp, 1);
        tick();

        // Two reads outstanding, then a one-cycle reset.
        set_req(0, 1, 0, 16'h0060, '0);
        exp_r(0, 0, 16'h0060, '0);
        tick();
        set_req(0, 1, 0, 16'h0061, '0);
        exp_r(0, 0, 16'h0061, '0);
        tick();
        r_req_vld = '0;
        rst_n = 1'b0;
        mid();
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_vld", m_req_vld, 0);
        tick();
        rst_n = 1'b1;
        mid();
        chk("s6_busy_after", busy, 0);
        chk("s6_err_cleared", err_rsp, 0);
        tick();
        m_rsp_vld  = 1'b1;
        m_rsp_data = 32'h0000_BEEF;
        mid();
        chk("s6_stray_rsp_vld", r_rsp_vld, 0);
        tick();
        m_rsp_vld = 1'b0;
        mid();
        chk("s6_err", err_rsp, 1);
        tick();

        // rr_ptr was 1 before reset; after reset r0 must win a tie.
        set_req(0, 1, 0, 16'h0070, '0);
        set_req(1, 1, 0, 16'h0071, '0);
        exp_r(0, 0, 16'h0070, '0);
        tick();
        r_req_vld = '0;
        respond(0, 32'h4444_0000);
        mid();
        chk("final_busy", busy, 0);
        chk("exp_req_left", exp_req.size(), 0);
        chk("exp_rsp_left", exp_rsp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
